nor_bus_if: RTL and testbench

- Timed parallel-NOR bus master sitting directly behind the FPGA pad layer.
- Converts single Wishbone-classic word accesses from the bridge core into NOR CE#/OE#/WE# cycles of programmable length.
- Drives the NOR address, data and strobe nets that the top level routes to the pins.
- Owns RY/BY# synchronisation and busy-wait before each access.

---
 rtl/nor_bus_if.sv | 159 +++++++++++++++
 tb/tb_nor_bus_if.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/nor_bus_if.sv
// Timed parallel-NOR bus master: one Wishbone-classic word access becomes one CE#/OE#/WE# cycle.
// Optional macro NOR_BUSY_TIMEOUT_EN bounds the RY/BY# wait and reports expiry on wb_err_o.
module nor_bus_if #(
    parameter int unsigned ADDRW  = 26,
    parameter int unsigned DATAW  = 16,
    parameter int unsigned T_RD   = 7,
    parameter int unsigned T_WR   = 4,
    parameter int unsigned T_HOLD = 2
`ifdef NOR_BUSY_TIMEOUT_EN
    ,
    parameter int unsigned BUSY_TO = 4096
`endif
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [ADDRW-1:0] wb_adr_i,
    input  logic [DATAW-1:0] wb_dat_i,
    output logic [DATAW-1:0] wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic [ADDRW-1:0] nor_addr_o,
    input  logic [DATAW-1:0] nor_data_i,
    output logic [DATAW-1:0] nor_data_o,
    output logic             nor_data_oe,
    output logic             nor_ce_o,
    output logic             nor_oe_o,
    output logic             nor_we_o,
    input  logic             nor_ry_i,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RY, S_SETUP, S_READ, S_WRITE, S_HOLD
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [7:0] r_cnt, w_cnt_nxt;
    logic       r_ry_m, r_ry_s;
    logic       r_we, r_ack_en;
    logic       w_last, w_accept, w_done, w_we_eff, w_doe_nxt, w_timeout;

    assign w_last = (r_cnt == 8'd0);
    // The final HOLD cycle doubles as the IDLE accept slot so back-to-back gaps are exactly T_HOLD.
    assign w_accept = (r_state == S_IDLE || (r_state == S_HOLD && w_last)) && wb_cyc_i && wb_stb_i;
    assign w_done   = (r_state == S_READ || r_state == S_WRITE) && w_last;
    assign w_we_eff = w_accept ? wb_we_i : r_we;

`ifdef NOR_BUSY_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_err;

    assign w_timeout = (r_state == S_WAIT_RY) && !r_ry_s && (r_to_cnt == 16'(BUSY_TO - 1));
    assign wb_err_o  = r_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_accept)
                r_to_cnt <= '0;
            else if (r_state == S_WAIT_RY)
                r_to_cnt <= r_to_cnt + 16'd1;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign wb_err_o  = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = r_ry_s ? S_SETUP : S_WAIT_RY;
            end
            S_WAIT_RY: begin
                if (r_ry_s)
                    w_state_nxt = S_SETUP;
                else if (w_timeout)
                    w_state_nxt = S_IDLE;
            end
            S_SETUP: begin
                w_state_nxt = r_we ? S_WRITE : S_READ;
                w_cnt_nxt   = r_we ? 8'(T_WR - 1) : 8'(T_RD - 1);
            end
            S_READ, S_WRITE: begin
                if (w_last) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = 8'(T_HOLD - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            S_HOLD: begin
                if (!w_last)
                    w_cnt_nxt = r_cnt - 8'd1;
                else if (w_accept)
                    w_state_nxt = r_ry_s ? S_SETUP : S_WAIT_RY;
                else
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // DQ drive covers SETUP, WRITE and the first HOLD cycle of a write only.
    assign w_doe_nxt = w_we_eff && (w_state_nxt == S_SETUP || w_state_nxt == S_WRITE ||
                                    (r_state == S_WRITE && w_state_nxt == S_HOLD));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_ry_m      <= 1'b1;
            r_ry_s      <= 1'b1;
            r_we        <= 1'b0;
            r_ack_en    <= 1'b0;
            nor_addr_o  <= '0;
            nor_data_o  <= '0;
            nor_data_oe <= 1'b0;
            nor_ce_o    <= 1'b1;
            nor_oe_o    <= 1'b1;
            nor_we_o    <= 1'b1;
            wb_dat_o    <= '0;
            wb_ack_o    <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            r_ry_m  <= nor_ry_i;
            r_ry_s  <= r_ry_m;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                nor_addr_o <= wb_adr_i;
                nor_data_o <= wb_dat_i;
                r_we       <= wb_we_i;
                r_ack_en   <= 1'b1;
            end else begin
                r_ack_en <= r_ack_en && wb_cyc_i;
            end
            if (r_state == S_READ && w_last)
                wb_dat_o <= nor_data_i;
            wb_ack_o    <= w_done && r_ack_en && wb_cyc_i;
            nor_ce_o    <= !(w_state_nxt == S_SETUP || w_state_nxt == S_READ ||
                             w_state_nxt == S_WRITE);
            nor_oe_o    <= (w_state_nxt != S_READ);
            nor_we_o    <= (w_state_nxt != S_WRITE);
            nor_data_oe <= w_doe_nxt;
            busy_o      <= (w_state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_nor_bus_if.sv
// Directed bench for nor_bus_if: per-cycle strobe masks compared against hand-derived timing.
module tb_nor_bus_if;

    localparam int ADDRW = 26;
    localparam int DATAW = 16;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
    logic [ADDRW-1:0] wb_adr_i = '0;
    logic [DATAW-1:0] wb_dat_i = '0;
    logic [DATAW-1:0] wb_dat_o;
    logic             wb_ack_o, wb_err_o;
    logic [ADDRW-1:0] nor_addr_o;
    logic [DATAW-1:0] nor_data_i = '0;
    logic [DATAW-1:0] nor_data_o;
    logic             nor_data_oe, nor_ce_o, nor_oe_o, nor_we_o;
    logic             nor_ry_i = 1'b1;
    logic             busy_o;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [63:0]      m_ce, m_oe, m_we, m_doe, m_ack, m_err, m_busy;
    logic [ADDRW-1:0] a_addr [64];
    logic [DATAW-1:0] a_ndo  [64];
    logic [DATAW-1:0] a_dato [64];

    nor_bus_if #(
        .ADDRW(ADDRW), .DATAW(DATAW), .T_RD(7), .T_WR(4), .T_HOLD(2)
`ifdef NOR_BUSY_TIMEOUT_EN
        , .BUSY_TO(16)
`endif
    ) dut (
        .clk_i(clk), .reset_i(reset_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .nor_addr_o(nor_addr_o), .nor_data_i(nor_data_i), .nor_data_o(nor_data_o),
        .nor_data_oe(nor_data_oe), .nor_ce_o(nor_ce_o), .nor_oe_o(nor_oe_o),
        .nor_we_o(nor_we_o), .nor_ry_i(nor_ry_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic we, input logic [ADDRW-1:0] adr, input logic [DATAW-1:0] dat);
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
    endtask

    // Cycle k is the clock period after accept edge k-1; sampling happens at its negedge.
    task automatic rec(input int n, input int ry_rise, input int rst_at, input int drop_at,
                       input bit b2b, input logic [ADDRW-1:0] adr2, input logic [DATAW-1:0] dat2);
        int acks = 0;
        m_ce = '0; m_oe = '0; m_we = '0; m_doe = '0; m_ack = '0; m_err = '0; m_busy = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            m_ce[k]   = !nor_ce_o;
            m_oe[k]   = !nor_oe_o;
            m_we[k]   = !nor_we_o;
            m_doe[k]  = nor_data_oe;
            m_ack[k]  = wb_ack_o;
            m_err[k]  = wb_err_o;
            m_busy[k] = busy_o;
            a_addr[k] = nor_addr_o;
            a_ndo[k]  = nor_data_o;
            a_dato[k] = wb_dat_o;
            if (wb_ack_o === 1'b1) begin
                acks++;
                if (b2b && acks == 1) begin
                    wb_adr_i = adr2;
                    wb_dat_i = dat2;
                end else begin
                    wb_cyc_i = 1'b0;
                    wb_stb_i = 1'b0;
                end
            end
            if (wb_err_o === 1'b1) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            if (k == ry_rise) nor_ry_i = 1'b1;
            if (k == drop_at) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            if (k == rst_at) begin
                reset_i  = 1'b1;
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            if (k == rst_at + 1) reset_i = 1'b0;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_strobes", {nor_ce_o, nor_oe_o, nor_we_o}, 3'b111);
        chk("rst_flags", {nor_data_oe, wb_ack_o, wb_err_o, busy_o}, 4'b0000);
        chk("rst_addr", nor_addr_o, '0);
        chk("rst_data", {nor_data_o, wb_dat_o}, '0);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);

        // Read, RY ready.
        nor_data_i = 16'hBEEF;
        req(1'b0, 26'h0012345, 16'h0000);
        rec(14, 0, 0, 0, 1'b0, '0, '0);
        chk("rd_addr_c1", a_addr[1], 26'h0012345);
        chk("rd_ce", m_ce, rng(1, 8));
        chk("rd_oe", m_oe, rng(2, 8));
        chk("rd_we", m_we, '0);
        chk("rd_doe", m_doe, '0);
        chk("rd_ack", m_ack, rng(9, 9));
        chk("rd_err", m_err, '0);
        chk("rd_busy", m_busy, rng(1, 10));
        chk("rd_dat", a_dato[9], 16'hBEEF);
        repeat (2) @(negedge clk);

        // Single write.
        req(1'b1, 26'h0000555, 16'h00AA);
        rec(10, 0, 0, 0, 1'b0, '0, '0);
        chk("wr_ce", m_ce, rng(1, 5));
        chk("wr_we", m_we, rng(2, 5));
        chk("wr_oe", m_oe, '0);
        chk("wr_doe", m_doe, rng(1, 6));
        chk("wr_ack", m_ack, rng(6, 6));
        chk("wr_busy", m_busy, rng(1, 7));
        chk("wr_ndo", a_ndo[3], 16'h00AA);
        chk("wr_addr", a_addr[4], 26'h0000555);
        repeat (2) @(negedge clk);

        // RY low at request; rises in cycle 20.
        nor_ry_i = 1'b0;
        repeat (4) @(negedge clk);
        nor_data_i = 16'h1234;
        req(1'b0, 26'h3FFFFFF, 16'h0000);
        rec(36, 20, 0, 0, 1'b0, '0, '0);
        chk("ry_ce", m_ce, rng(23, 30));
        chk("ry_oe", m_oe, rng(24, 30));
        chk("ry_ack", m_ack, rng(31, 31));
        chk("ry_busy", m_busy, rng(1, 32));
        chk("ry_dat", a_dato[31], 16'h1234);
        chk("ry_addr", a_addr[1], 26'h3FFFFFF);
        repeat (2) @(negedge clk);

        // Back-to-back writes with stb held across the first ack.
        req(1'b1, 26'h0000AAA, 16'h0055);
        rec(18, 0, 0, 0, 1'b1, 26'h1000001, 16'hC3C3);
        chk("b2b_ce", m_ce, rng(1, 5) | rng(8, 12));
        chk("b2b_we", m_we, rng(2, 5) | rng(9, 12));
        chk("b2b_oe", m_oe, '0);
        chk("b2b_doe", m_doe, rng(1, 6) | rng(8, 13));
        chk("b2b_ack", m_ack, rng(6, 6) | rng(13, 13));
        chk("b2b_busy", m_busy, rng(1, 14));
        chk("b2b_addr2", a_addr[8], 26'h1000001);
        chk("b2b_ndo2", a_ndo[10], 16'hC3C3);
        chk("b2b_ndo1", a_ndo[7], 16'h0055);
        repeat (2) @(negedge clk);

        // Reset asserted in the second WE#-low cycle.
        req(1'b1, 26'h0000777, 16'h9999);
        rec(10, 0, 3, 0, 1'b0, '0, '0);
        chk("rst_ce", m_ce, rng(1, 3));
        chk("rst_we", m_we, rng(2, 3));
        chk("rst_doe", m_doe, rng(1, 3));
        chk("rst_ack", m_ack, '0);
        chk("rst_busy", m_busy, rng(1, 3));
        repeat (2) @(negedge clk);

        // wb_cyc_i dropped mid-read: full NOR timing, no ack, data still captured.
        nor_data_i = 16'h5A5A;
        req(1'b0, 26'h0000100, 16'h0000);
        rec(14, 0, 0, 2, 1'b0, '0, '0);
        chk("drop_ce", m_ce, rng(1, 8));
        chk("drop_oe", m_oe, rng(2, 8));
        chk("drop_ack", m_ack, '0);
        chk("drop_dat", a_dato[12], 16'h5A5A);
        repeat (2) @(negedge clk);

`ifdef NOR_BUSY_TIMEOUT_EN
        nor_ry_i = 1'b0;
        repeat (4) @(negedge clk);
        req(1'b0, 26'h0002222, 16'h0000);
        rec(24, 0, 0, 0, 1'b0, '0, '0);
        chk("to_err", m_err, rng(17, 17));
        chk("to_ce", m_ce, '0);
        chk("to_busy", m_busy, rng(1, 16));
        chk("to_addr", a_addr[20], 26'h0002222);
        nor_ry_i = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
